mux_scan_serializer: RTL and testbench
======================================

# mux_scan_serializer

Parallel-to-serial front end for the 8:1 bit multiplexer. Accepts an 8-bit word over a valid/ready handshake, latches it, and steps the 3-bit select through all eight positions, one per accepted output beat. Sits directly upstream of the mux: the block owns the `Sel` sequence and the `A` data, and presents the selected bit downstream with its own valid/ready handshake. Back-to-back words stream with no idle cycle.

## Interface
- `LSB_FIRST`, default 1: 1 means `Sel` counts 0→7; 0 means `Sel` counts 7→0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `Din` holds a word to load.
- `in_ready` out 1: block can accept a word this cycle.
- `Din` in 8: parallel input word.
- `Sel` out 3: current select, also driven into the mux instance.
- `F` out 1: selected bit, equal to `A[Sel]` of the latched word.
- `out_valid` out 1: `F` is a valid serial beat.
- `out_ready` in 1: downstream accepts the beat.
- `last` out 1: current beat is the eighth bit of the word.

## Operation
- **Word acceptance.** A word is accepted when `in_valid & in_ready` at a rising edge. `A` (8-bit register) ← `Din`, and `Sel` ← start value: 0 if `LSB_FIRST`, else 7.
- **A beat.** A beat transfers when `out_valid & out_ready` at a rising edge.
- **States.**
  - IDLE: `in_ready`=1, `out_valid`=0.
    - IDLE → SHIFT on acceptance.
  - SHIFT: `out_valid`=1. On a beat:
    - If not last: `Sel` advances by ±1; stay in SHIFT.
    - If last and `in_valid`=1: reload, stay in SHIFT.
    - If last and `in_valid`=0: go to IDLE.
- **`last`.** Asserted in SHIFT when `Sel` equals the end value (7 if `LSB_FIRST`, else 0). It is 0 in IDLE.
- **`in_ready`.** Equals `rst`=0 & (IDLE | (SHIFT & `last` & `out_ready`)). This allows a new word to load in the same cycle the final beat transfers.
- **Stall.** `out_ready`=0 in SHIFT holds `Sel`, `A`, `F` and `last` unchanged for any number of cycles. `in_valid` is ignored while `in_ready`=0.
- **`F`.** Purely combinational from `A` and `Sel`, with no extra register stage. `F` is don't-care in IDLE but is still defined as `A[Sel]`.
- **Reset.** Reset at any time, including mid-word, discards the partial word:
  - state → IDLE, `A` → 8'h00, `Sel` → 3'b000.
  - `out_valid`=0, `last`=0, `in_ready`=0 while `rst` is high.
  - `F`=0 follows from `A`=0.
- **Sel bounds.** `Sel` never wraps inside a word. Advancement stops at the end value; the only way past it is a reload or the return to IDLE.

## Timing
- **Accept-to-beat latency.** Word accepted at edge N → first beat valid in cycle N+1 (one cycle).
- **Throughput.** With `out_ready` held high, one bit per cycle. A word takes 8 cycles. Continuous streaming gives 8 bits per 8 cycles with no bubble.
- **Recovery from reset.** First edge after `rst` deasserts: `in_ready`=1 in that cycle, so the earliest acceptance is the first edge with `rst` low.
- **Outputs.** `in_ready`, `out_valid` and `last` are combinational from state, `Sel` and `out_ready`; none of them combinationally depends on `in_valid`.

## Structure
- **Shared package** holds:
  - state enum {IDLE, SHIFT}.
  - constants `SEL_W`=3 and `DATA_W`=8.
  - start/end select values as functions of `LSB_FIRST`.
- **Sub-module.** One instance of the existing case-statement 8:1 mux (`mux8_1cond`), driven by `A` and `Sel` and producing `F`. This keeps the bit selection in a single place.
- **Remainder of the block:**
  - FSM.
  - 3-bit up/down counter.
  - 8-bit load register.

## Test plan
- **Single word, LSB first.** Reset, then `Din`=8'b1011_0010 with `in_valid` for one cycle, `out_ready`=1.
  - `F` sequence = 0,1,0,0,1,1,0,1 with `Sel` = 0..7.
  - `last` high only on the 8th beat.
  - Returns to IDLE with `in_ready`=1.
- **MSB first (`LSB_FIRST`=0).** `Din`=8'hA5 → `F` = 1,0,1,0,0,1,0,1 with `Sel` = 7..0.
- **Back-to-back.** Words 8'hFF then 8'h00 with `in_valid` held high. The second word loads on the 8th beat edge of the first, giving 16 consecutive valid beats: eight 1s, then eight 0s, with `out_valid` never low.
- **Stall.** Deassert `out_ready` for 5 cycles at `Sel`=3.
  - `Sel`, `F` and `last` remain stable throughout.
  - Resume yields the remaining bits in order; total beats = 8.
- **Reset mid-word.** Assert `rst` at `Sel`=4.
  - Next cycle: `out_valid`=0, `Sel`=0, `A`=0.
  - After release, a new word 8'h3C serialises from bit 0 correctly.
- **Ignored input.** Pulse `in_valid` with a different `Din` during a non-last beat. The latched word is unchanged and all 8 original bits are output.

Source files
------------

// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial front end.
// The select start/end values depend only on the shift direction.
package mux_scan_serializer_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/mux8_1cond.sv
// Case-statement 8:1 bit multiplexer: F = A[Sel].
module mux8_1cond
    import mux_scan_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [SEL_W-1:0]  Sel,
    output logic              F
);

    always_comb begin
        F = 1'b0;
        case (Sel)
            3'd0: F = A[0];
            3'd1: F = A[1];
            3'd2: F = A[2];
            3'd3: F = A[3];
            3'd4: F = A[4];
            3'd5: F = A[5];
            3'd6: F = A[6];
            3'd7: F = A[7];
            default: F = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Latches an 8-bit word and walks the mux select through all eight bits,
// one per downstream beat, reloading on the final beat so words stream back to back.
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Din,
    output logic [SEL_W-1:0]  Sel,
    output logic              F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_END   = sel_end(LSB_FIRST);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                accept;
    logic                beat;

    // Handshake outputs are gated by rst so nothing is offered while reset is held.
    always_comb begin
        out_valid = (state_q == SHIFT) && !rst;
        last      = out_valid && (sel_q == SEL_END);
        in_ready  = !rst && ((state_q == IDLE) || (last && out_ready));
        accept    = in_valid && in_ready;
        beat      = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sel_d   = sel_q;
        if (accept) begin
            a_d     = Din;
            sel_d   = SEL_START;
            state_d = SHIFT;
        end else if (beat) begin
            if (!last) begin
                sel_d = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sel_q   <= sel_d;
        end
    end

    assign Sel = sel_q;

    mux8_1cond u_mux (
        .A   (a_q),
        .Sel (sel_q),
        .F   (F)
    );

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Randomised and directed bench comparing both shift directions against a beat-index model.
module tb_mux_scan_serializer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] Din;
    logic       out_ready;

    logic       in_ready_l, F_l, out_valid_l, last_l;
    logic [2:0] Sel_l;
    logic       in_ready_m, F_m, out_valid_m, last_m;
    logic [2:0] Sel_m;

    int checks = 0;
    int errors = 0;

    // Reference model: a word, the index of the current beat (0..7) and a busy flag.
    logic [7:0] m_word;
    int         m_idx;
    bit         m_busy;
    bit         m_fresh;

    mux_scan_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .Din       (Din),
        .Sel       (Sel_l),
        .F         (F_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .last      (last_l)
    );

    mux_scan_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .Din       (Din),
        .Sel       (Sel_m),
        .F         (F_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .last      (last_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input bit iv, input logic [7:0] din, input bit ordy, input bit r);
        bit exp_ready;
        bit exp_valid;
        bit exp_last;
        int sel_lsb;
        int sel_msb;
        @(negedge clk);
        in_valid  = iv;
        Din       = din;
        out_ready = ordy;
        rst       = r;
        #1;
        exp_valid = m_busy && !r;
        exp_last  = exp_valid && (m_idx == 7);
        exp_ready = !r && (!m_busy || ((m_idx == 7) && ordy));
        sel_lsb   = m_idx;
        sel_msb   = 7 - m_idx;
        checkOutput("lsb_out_valid", {7'd0, out_valid_l}, {7'd0, exp_valid});
        checkOutput("msb_out_valid", {7'd0, out_valid_m}, {7'd0, exp_valid});
        checkOutput("lsb_last",      {7'd0, last_l},      {7'd0, exp_last});
        checkOutput("msb_last",      {7'd0, last_m},      {7'd0, exp_last});
        checkOutput("lsb_in_ready",  {7'd0, in_ready_l},  {7'd0, exp_ready});
        checkOutput("msb_in_ready",  {7'd0, in_ready_m},  {7'd0, exp_ready});
        if (m_busy) begin
            checkOutput("lsb_sel", {5'd0, Sel_l}, 8'(sel_lsb));
            checkOutput("msb_sel", {5'd0, Sel_m}, 8'(sel_msb));
            checkOutput("lsb_f", {7'd0, F_l}, {7'd0, m_word[sel_lsb]});
            checkOutput("msb_f", {7'd0, F_m}, {7'd0, m_word[sel_msb]});
        end else if (m_fresh) begin
            checkOutput("lsb_sel_reset", {5'd0, Sel_l}, 8'd0);
            checkOutput("msb_sel_reset", {5'd0, Sel_m}, 8'd0);
            checkOutput("lsb_f_reset", {7'd0, F_l}, 8'd0);
            checkOutput("msb_f_reset", {7'd0, F_m}, 8'd0);
        end
        @(posedge clk);
        if (r) begin
            m_busy  = 1'b0;
            m_word  = 8'h00;
            m_idx   = 0;
            m_fresh = 1'b1;
        end else if (m_busy && ordy) begin
            if (m_idx < 7) begin
                m_idx++;
            end else if (iv) begin
                m_word = din;
                m_idx  = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else if (!m_busy && iv) begin
            m_word  = din;
            m_idx   = 0;
            m_busy  = 1'b1;
            m_fresh = 1'b0;
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        Din       = 8'h00;
        out_ready = 1'b1;
        rst       = 1'b1;
        m_word    = 8'h00;
        m_idx     = 0;
        m_busy    = 1'b0;
        m_fresh   = 1'b0;

        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 1, 1);

        // Single word 8'b1011_0010, then drain back to idle.
        applyStimulus(1, 8'hB2, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);

        applyStimulus(1, 8'hA5, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);

        // Back-to-back FF then 00 with in_valid held high.
        applyStimulus(1, 8'hFF, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);

        // Stall at beat 3 with a competing word offered that must be ignored.
        applyStimulus(1, 8'h6E, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h91, 0, 0);
        applyStimulus(1, 8'h91, 1, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 1, 0);

        // Reset mid-word, then a fresh word 8'h3C.
        applyStimulus(1, 8'hD7, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(1, 8'h3C, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);

        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 60) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
